// File: rtl/counter_sched_pkg.sv
// rtl/counter_sched_pkg.sv - shared types and defaults for the counter scheduler
// Purpose: FSM state encoding and default parameter values used by
//          counter_sched and counter_sched_arb.
// Contents: STATE_W, NUM_REQ_DEF, CNT_W_DEF, state_e.
package counter_sched_pkg;

    localparam int STATE_W     = 2;
    localparam int NUM_REQ_DEF = 4;
    localparam int CNT_W_DEF   = 4;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/counter_sched_arb.sv
// rtl/counter_sched_arb.sv - combinational requester selection
// Purpose: picks one requester from req_i.
//   Default: round-robin, search starts at ptr_i and wraps.
//   COUNTER_SCHED_FIXED_PRIO_EN defined: lowest index wins, ptr_i unused.
// Ports:
//   req_i  in  NUM_REQ  request vector
//   ptr_i  in  IDX_W    round-robin start index
//   gnt_o  out NUM_REQ  one-hot winner (0 when no request)
//   idx_o  out IDX_W    winner index
//   any_o  out 1        at least one request present
module counter_sched_arb #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    int   cand;
    logic found;

`ifdef COUNTER_SCHED_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr_i;
`endif

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
`ifdef COUNTER_SCHED_FIXED_PRIO_EN
            cand = k;
`else
            cand = (int'(ptr_i) + k) % NUM_REQ;
`endif
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                idx_o       = IDX_W'(cand);
                gnt_o[cand] = 1'b1;
            end
        end
    end

    assign any_o = found;

endmodule

// File: rtl/counter_sched.sv
// rtl/counter_sched.sv - schedules runs of a shared enable/clear counter
// Purpose: arbitrates NUM_REQ requesters for one external counter; clears it,
//   enables it for exactly len increments, then pulses done for the owner.
//   Selection policy set by COUNTER_SCHED_FIXED_PRIO_EN (see counter_sched_arb).
// Ports:
//   clock       in  1              rising-edge clock
//   reset_n     in  1              asynchronous active-low reset
//   req         in  NUM_REQ        level requests, held until done
//   req_len     in  NUM_REQ*CNT_W  run length per requester
//   grant       out NUM_REQ        registered one-hot owner
//   busy        out 1              grant != 0
//   done        out NUM_REQ        registered one-cycle completion pulse
//   cnt_clear   out 1              counter sync clear
//   cnt_enable  out 1              counter enable
//   cnt_value   in  CNT_W          counter value
module counter_sched
    import counter_sched_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CNT_W-1:0] req_len,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     busy,
    output logic [NUM_REQ-1:0]       done,
    output logic                     cnt_clear,
    output logic                     cnt_enable,
    input  logic [CNT_W-1:0]         cnt_value
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     len_q, len_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   done_q, done_d;

    logic [NUM_REQ-1:0]   win_onehot;
    logic [IDX_W-1:0]     win_idx;
    logic                 win_any;
    logic                 owner_req;
    logic [IDX_W-1:0]     owner_next;

    counter_sched_arb #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .gnt_o   (win_onehot),
        .idx_o   (win_idx),
        .any_o   (win_any)
    );

    assign owner_req  = req[owner_q];
    assign owner_next = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        done_d  = '0;
        case (state_q)
            IDLE: begin
                if (win_any) begin
                    len_d   = req_len[int'(win_idx)*CNT_W +: CNT_W];
                    owner_d = win_idx;
                    grant_d = win_onehot;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                if (!owner_req) begin
                    // abort: release without done, skip past the owner
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = owner_next;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!owner_req) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = owner_next;
                end else if (cnt_value == len_q) begin
                    state_d = DONE;
                    grant_d = '0;
                    done_d  = grant_q;
                end
            end
            DONE: begin
                ptr_d   = owner_next;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign grant      = grant_q;
    assign done       = done_q;
    assign busy       = |grant_q;
    assign cnt_clear  = (state_q == CLEAR);
    // req gate makes an abort stop counting in the same cycle the request drops
    assign cnt_enable = (state_q == RUN) && owner_req && (cnt_value != len_q);

endmodule

// File: tb/tb_counter_sched.sv
// tb/tb_counter_sched.sv - scoreboard bench for counter_sched
module tb_counter_sched;

    localparam int N = 4;
    localparam int W = 4;

    logic           clock   = 1'b0;
    logic           reset_n = 1'b0;
    logic [N-1:0]   req     = '0;
    logic [N*W-1:0] req_len = '0;
    logic [N-1:0]   grant;
    logic           busy;
    logic [N-1:0]   done;
    logic           cnt_clear;
    logic           cnt_enable;
    logic [W-1:0]   cnt_value = 4'd9;

    counter_sched #(.NUM_REQ(N), .CNT_W(W)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req        (req),
        .req_len    (req_len),
        .grant      (grant),
        .busy       (busy),
        .done       (done),
        .cnt_clear  (cnt_clear),
        .cnt_enable (cnt_enable),
        .cnt_value  (cnt_value)
    );

    always #5 clock = ~clock;

    // shared counter model: not reset by reset_n
    always @(posedge clock) begin
        if (cnt_clear)       cnt_value <= '0;
        else if (cnt_enable) cnt_value <= cnt_value + 1'b1;
    end

    typedef struct {
        logic [N-1:0] owner;
        int           gcyc;
        int           ccyc;
        int           ecyc;
        logic [W-1:0] val;
        logic [N-1:0] dn;
    } exp_t;

    exp_t expq[$];
    exp_t cur_e;
    int   tests = 0;
    int   fails = 0;
    int   stray = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic push(input logic [N-1:0] owner, input int g, input int c, input int e,
                        input logic [W-1:0] val, input logic [N-1:0] dn);
        exp_t x;
        x.owner = owner; x.gcyc = g; x.ccyc = c; x.ecyc = e; x.val = val; x.dn = dn;
        expq.push_back(x);
    endtask

    // monitor: one scoreboard entry per grant session, compared when grant drops
    logic [N-1:0] prev_grant = '0;
    logic [N-1:0] cur_owner  = '0;
    int gcyc = 0, ccyc = 0, ecyc = 0, bad = 0;

    always @(negedge clock) begin
        if (!reset_n) begin
            prev_grant = '0;
        end else begin
            if (grant != '0 && prev_grant == '0) begin
                cur_owner = grant; gcyc = 0; ccyc = 0; ecyc = 0; bad = 0;
            end
            if (grant != '0) begin
                gcyc++;
                if (cnt_clear)  ccyc++;
                if (cnt_enable) ecyc++;
                if (grant != cur_owner) bad++;
            end else if (cnt_clear || cnt_enable) begin
                stray++;
            end
            if (busy !== (grant != '0)) stray++;
            if (grant == '0 && prev_grant != '0) begin
                if (expq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL sb_empty: session owner %b had no expected entry", cur_owner);
                end else begin
                    cur_e = expq.pop_front();
                    check("owner",       cur_owner, cur_e.owner);
                    check("grant_cycles", gcyc, cur_e.gcyc);
                    check("clear_cycles", ccyc, cur_e.ccyc);
                    check("enable_cycles", ecyc, cur_e.ecyc);
                    check("cnt_value_end", cnt_value, cur_e.val);
                    check("done_pulse",  done, cur_e.dn);
                    check("owner_stable", bad, 0);
                end
            end else if (done != '0) begin
                stray++;
            end
            prev_grant = grant;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_len(input int i, input logic [W-1:0] l);
        req_len[i*W +: W] = l;
    endtask

    task automatic wait_grant(input logic [N-1:0] mask, input string name);
        for (int k = 0; k < 50 && (grant & mask) == '0; k++) tick();
        if ((grant & mask) == '0) begin
            tests++; fails++;
            $display("FAIL %s: grant timeout, grant=%b expected mask %b", name, grant, mask);
        end
    endtask

    task automatic wait_done(input logic [N-1:0] mask, input string name);
        for (int k = 0; k < 200 && (done & mask) == '0; k++) tick();
        if ((done & mask) == '0) begin
            tests++; fails++;
            $display("FAIL %s: done timeout, done=%b expected mask %b", name, done, mask);
        end
    endtask

    initial begin
        tick();
        tick();
        check("rst_grant", grant, 0);
        check("rst_done", done, 0);
        check("rst_clear", cnt_clear, 0);
        check("rst_enable", cnt_enable, 0);
        check("rst_busy", busy, 0);
        reset_n = 1'b1;
        tick();

        // req0 L=3, req_len change after grant must be ignored
        set_len(0, 4'd3);
        push(4'b0001, 5, 1, 3, 4'd3, 4'b0001);
        req = 4'b0001;
        wait_grant(4'b0001, "t2");
        set_len(0, 4'd9);
        wait_done(4'b0001, "t2");
        req = '0;
        tick();

        // req2 L=0
        set_len(2, 4'd0);
        push(4'b0100, 2, 1, 0, 4'd0, 4'b0100);
        req = 4'b0100;
        wait_done(4'b0100, "t3");
        req = '0;
        tick();

        // reset mid-run: outputs drop before any clock edge, counter untouched
        set_len(0, 4'd7);
        req = 4'b0001;
        wait_grant(4'b0001, "t1");
        tick(); tick(); tick();
        reset_n = 1'b0;
        #1;
        check("t1_grant", grant, 0);
        check("t1_done", done, 0);
        check("t1_clear", cnt_clear, 0);
        check("t1_enable", cnt_enable, 0);
        check("t1_busy", busy, 0);
        req = '0;
        tick();
        tick();
        check("t1_cnt_kept", cnt_value, 2);
        reset_n = 1'b1;
        tick();

        // all four requesting, L=1 each
        for (int i = 0; i < N; i++) set_len(i, 4'd1);
`ifdef COUNTER_SCHED_FIXED_PRIO_EN
        for (int s = 0; s < 5; s++) push(4'b0001, 3, 1, 1, 4'd1, 4'b0001);
`else
        push(4'b0001, 3, 1, 1, 4'd1, 4'b0001);
        push(4'b0010, 3, 1, 1, 4'd1, 4'b0010);
        push(4'b0100, 3, 1, 1, 4'd1, 4'b0100);
        push(4'b1000, 3, 1, 1, 4'd1, 4'b1000);
        push(4'b0001, 3, 1, 1, 4'd1, 4'b0001);
`endif
        req = 4'b1111;
        for (int s = 0; s < 5; s++) begin
            wait_done(4'b1111, "t4");
            if (s < 4) tick();
        end
        req = '0;
        tick();

        // req1 L=5 aborted after two increments, req2 L=1 pending
        set_len(1, 4'd5);
        set_len(2, 4'd1);
        push(4'b0010, 4, 1, 2, 4'd2, 4'b0000);
        push(4'b0100, 3, 1, 1, 4'd1, 4'b0100);
        req = 4'b0110;
        wait_grant(4'b0010, "t5");
        tick(); tick(); tick();
        req[1] = 1'b0;
        wait_done(4'b0100, "t5");
        req = '0;
        tick();

        // req3 L=15: full range, no wrap
        set_len(3, 4'd15);
        push(4'b1000, 17, 1, 15, 4'd15, 4'b1000);
        req = 4'b1000;
        wait_done(4'b1000, "t6");
        req = '0;
        tick(); tick(); tick();

        check("sb_drained", expq.size(), 0);
        check("stray_activity", stray, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
